// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// Package: uart_pkg
// Shared constants for fifo_uart_tx and its baud_tick_gen sub-module:
//   - frame FSM state encoding (3-bit) and the typed state enum built on it
//   - TX_IDLE_LEVEL, the level the serial line rests at
//   - frame_cycles(), the POP-to-end-of-STOP frame length
// Optional build macro: FIFO_UART_TX_PARITY_EN (adds one even-parity bit per frame).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StPop    = ST_POP,
        StLoad   = ST_LOAD,
        StStart  = ST_START,
        StData   = ST_DATA,
        StParity = ST_PARITY,
        StStop   = ST_STOP
    } tx_state_e;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    // POP and LOAD each take one cycle before the start bit.
    localparam int unsigned FRAME_OVERHEAD_CYCLES = 2;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned frame_cycles(input int unsigned data_w,
                                                 input int unsigned clks_per_bit,
                                                 input int unsigned stop_bits);
        return FRAME_OVERHEAD_CYCLES + (1 + data_w + PARITY_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// Module: baud_tick_gen
// Bit-period timer for fifo_uart_tx. Counts 0..CLKS_PER_BIT-1 and wraps.
// Ports:
//   rclk       in  read-domain clock
//   rrst       in  asynchronous active-high reset
//   clr        in  forces the counter to 0 on the next edge (bit period restarts)
//   tick       out high in the last cycle of each bit period
//   tick_next  out high one cycle before tick; lets the parent register outputs
//                  that must be high during the last cycle of a bit
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic rclk,
    input  logic rrst,
    input  logic clr,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick      = (cnt_q == CNT_LAST);
    // CLKS_PER_BIT >= 2, so after a clear the next cycle is never the last one.
    assign tick_next = !clr && (cnt_q == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// Module: fifo_uart_tx
// Read-side consumer of an asynchronous FIFO, in the FIFO read-clock domain.
// Pops one byte whenever the FIFO is non-empty and sends it as a UART frame:
// start bit, DATA_W data bits LSB first, [even parity], STOP_BITS stop bits.
// Optional build macro: FIFO_UART_TX_PARITY_EN inserts the parity bit.
// Ports:
//   rclk        in  read-domain clock
//   rrst        in  asynchronous active-high reset (drops any frame in flight)
//   fifo_empty  in  FIFO empty flag, only looked at while idle
//   fifo_dout   in  FIFO read data, valid the cycle after fifo_ren
//   fifo_ren    out one-cycle FIFO read pulse per frame
//   tx          out serial line, idles high
//   busy        out high whenever a frame is in progress
//   frame_done  out one-cycle pulse in the last cycle of the final stop bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_ren,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    // One index counter serves both data bits and stop bits.
    localparam int unsigned IDX_N = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int unsigned IDX_W = (IDX_N > 1) ? $clog2(IDX_N) : 1;
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              fifo_ren_q;
    logic              busy_q;
    logic              frame_done_q, frame_done_d;
    logic              tick, tick_next, clr;

`ifdef FIFO_UART_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .rclk     (rclk),
        .rrst     (rrst),
        .clr      (clr),
        .tick     (tick),
        .tick_next(tick_next)
    );

    // tx_d is the line level for the cycle after this one, so every bit change
    // is decided in the last cycle of the previous bit.
    always_comb begin
        state_d      = state_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        clr          = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StLoad;
            end
            StLoad: begin
                clr       = 1'b1;
                shift_d   = fifo_dout;
                bit_idx_d = '0;
                tx_d      = 1'b0;
                state_d   = StStart;
`ifdef FIFO_UART_TX_PARITY_EN
                parity_d  = ^fifo_dout;
`endif
            end
            StStart: begin
                if (tick) begin
                    tx_d    = shift_q[0];
                    state_d = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        tx_d    = parity_q;
                        state_d = StParity;
`else
                        tx_d    = TX_IDLE_LEVEL;
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    tx_d    = TX_IDLE_LEVEL;
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                // Registered pulse must land on the final cycle, so look one ahead.
                frame_done_d = tick_next && (bit_idx_q == LAST_STOP);
                if (tick) begin
                    if (bit_idx_q == LAST_STOP) begin
                        bit_idx_d = '0;
                        state_d   = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = TX_IDLE_LEVEL;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q      <= StIdle;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= TX_IDLE_LEVEL;
            fifo_ren_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            // POP is only entered from IDLE with the FIFO non-empty.
            fifo_ren_q   <= (state_d == StPop);
            busy_q       <= (state_d != StIdle);
            frame_done_q <= frame_done_d;
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign fifo_ren   = fifo_ren_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// Testbench: tb_fifo_uart_tx
// Drives fifo_uart_tx (CLKS_PER_BIT=4, STOP_BITS=1) from a behavioural FIFO with
// one-cycle read latency. Expected line waveforms come from a table of hand-worked
// frames and from a bit-list model of the UART frame format.
// Honours FIFO_UART_TX_PARITY_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int unsigned CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned FB   = 1 + 8 + PB + 1;   // line bits per frame
    localparam int unsigned FLEN = 2 + FB * CPB;      // POP cycle .. last stop cycle

    logic       rclk = 1'b0;
    logic       rrst = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_ren, tx, busy, frame_done;

    // Behavioural FIFO
    logic [7:0] mem [256];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int ren_cnt = 0;
    int ren_on_empty = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] data;
        logic [0:9] exp_np;   // start, d0..d7, stop in time order
        logic       exp_par;
    } vec_t;

    vec_t tbl [7];

    fifo_uart_tx #(
        .DATA_W      (8),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (1)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_ren  (fifo_ren),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 rclk = ~rclk;

    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge rclk) begin
        if (fifo_ren) begin
            ren_cnt <= ren_cnt + 1;
            if (fifo_empty) begin
                ren_on_empty <= ren_on_empty + 1;
            end else begin
                fifo_dout <= mem[rd_cnt % 256];
                rd_cnt    <= rd_cnt + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_cnt % 256] = b;
        wr_cnt++;
    endtask

    // Frame as line bits in time order, from the frame rules.
    function automatic logic [0:FB-1] model_bits(input logic [7:0] b);
        logic [0:FB-1] v;
        v[0] = 1'b0;
        for (int i = 0; i < 8; i++) v[1+i] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
        v[9] = ^b;
`endif
        v[FB-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [0:FB-1] table_bits(input vec_t t);
`ifdef FIFO_UART_TX_PARITY_EN
        return {t.exp_np[0:8], t.exp_par, t.exp_np[9]};
`else
        return t.exp_np;
`endif
    endfunction

    // Waits (bounded) for the POP cycle, then checks every cycle of the frame and
    // the idle cycle after it. Optionally pushes a byte into the FIFO mid-frame.
    task automatic run_frame(input logic [0:FB-1] bits, input int push_k,
                             input logic [7:0] push_val, input string tag,
                             output int waited);
        waited = 0;
        while (fifo_ren !== 1'b1 && waited < 20) begin
            @(negedge rclk);
            waited++;
        end
        if (fifo_ren !== 1'b1) begin
            check($sformatf("%s pop_timeout", tag), fifo_ren, 1'b1);
            return;
        end
        for (int k = 0; k < FLEN; k++) begin
            logic exp_tx;
            exp_tx = (k < 2) ? 1'b1 : bits[(k - 2) / CPB];
            check($sformatf("%s k%0d tx", tag, k), tx, exp_tx);
            check($sformatf("%s k%0d frame_done", tag, k), frame_done, (k == FLEN - 1));
            check($sformatf("%s k%0d busy", tag, k), busy, 1'b1);
            check($sformatf("%s k%0d fifo_ren", tag, k), fifo_ren, (k == 0));
            if (k == push_k) push(push_val);
            @(negedge rclk);
        end
        check($sformatf("%s after tx", tag), tx, 1'b1);
        check($sformatf("%s after busy", tag), busy, 1'b0);
        check($sformatf("%s after frame_done", tag), frame_done, 1'b0);
    endtask

    initial begin
        int         waited;
        int         ren0;
        int         r;
        int         pk;
        logic [7:0] b;
        logic [7:0] nb;
        logic [7:0] exp_q[$];

        tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
        tbl[1] = '{8'h01, 10'b0100000001, 1'b1};
        tbl[2] = '{8'h80, 10'b0000000011, 1'b1};
        tbl[3] = '{8'hFF, 10'b0111111111, 1'b0};
        tbl[4] = '{8'h3C, 10'b0001111001, 1'b0};
        tbl[5] = '{8'h07, 10'b0111000001, 1'b1};
        tbl[6] = '{8'h03, 10'b0110000001, 1'b0};

        // Reset values
        repeat (3) @(negedge rclk);
        check("reset tx", tx, 1'b1);
        check("reset fifo_ren", fifo_ren, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        rrst = 1'b0;
        repeat (2) @(negedge rclk);

        // Directed single frames from the table
        for (int i = 0; i < 7; i++) begin
            ren0 = ren_cnt;
            push(tbl[i].data);
            run_frame(table_bits(tbl[i]), -1, 8'h00, $sformatf("tbl%0d", i), waited);
            check($sformatf("tbl%0d pop_latency", i), waited, 1);
            check($sformatf("tbl%0d ren_pulses", i), ren_cnt - ren0, 1);
            check($sformatf("tbl%0d empty_after", i), fifo_empty, 1'b1);
        end

        // Three queued bytes: back-to-back frames with a 3-cycle high gap
        ren0 = ren_cnt;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        run_frame(model_bits(8'h01), -1, 8'h00, "b2b0", waited);
        check("b2b0 pop_latency", waited, 1);
        run_frame(model_bits(8'h80), -1, 8'h00, "b2b1", waited);
        check("b2b1 gap", waited, 1);
        run_frame(model_bits(8'hFF), -1, 8'h00, "b2b2", waited);
        check("b2b2 gap", waited, 1);
        check("b2b ren_pulses", ren_cnt - ren0, 3);
        check("b2b empty_after", fifo_empty, 1'b1);

        // Empty FIFO for 100 cycles
        for (int i = 0; i < 100; i++) begin
            check($sformatf("idle%0d fifo_ren", i), fifo_ren, 1'b0);
            check($sformatf("idle%0d tx", i), tx, 1'b1);
            check($sformatf("idle%0d busy", i), busy, 1'b0);
            @(negedge rclk);
        end

        // Asynchronous reset during the start bit, between clock edges
        ren0 = ren_cnt;
        push(8'hA5);
        waited = 0;
        while (fifo_ren !== 1'b1 && waited < 20) begin
            @(negedge rclk);
            waited++;
        end
        check("arst pop", fifo_ren, 1'b1);
        repeat (3) @(negedge rclk);
        check("arst pre tx", tx, 1'b0);
        #2 rrst = 1'b1;
        #1;
        check("arst tx", tx, 1'b1);
        check("arst busy", busy, 1'b0);
        check("arst fifo_ren", fifo_ren, 1'b0);
        @(negedge rclk);
        rrst = 1'b0;
        repeat (3) @(negedge rclk);
        check("arst stays idle", busy, 1'b0);
        check("arst ren_pulses", ren_cnt - ren0, 1);

        // Reset in the third data bit of 0x3C; next byte must go out intact
        ren0 = ren_cnt;
        push(8'h3C);
        push(8'h96);
        waited = 0;
        while (fifo_ren !== 1'b1 && waited < 20) begin
            @(negedge rclk);
            waited++;
        end
        check("mrst pop", fifo_ren, 1'b1);
        repeat (15) @(negedge rclk);
        check("mrst pre busy", busy, 1'b1);
        check("mrst pre tx", tx, 1'b1);
        #2 rrst = 1'b1;
        #1;
        check("mrst tx", tx, 1'b1);
        check("mrst busy", busy, 1'b0);
        check("mrst frame_done", frame_done, 1'b0);
        @(negedge rclk);
        rrst = 1'b0;
        run_frame(model_bits(8'h96), -1, 8'h00, "mrst next", waited);
        check("mrst next pop_latency", waited, 1);
        check("mrst ren_pulses", ren_cnt - ren0, 2);

        // Randomized traffic, including pushes that arrive mid-frame
        r = 0;
        while (r < 30 || exp_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                int gap;
                int n;
                gap = int'($urandom_range(0, 4));
                n   = int'($urandom_range(1, 3));
                for (int g = 0; g < gap; g++) begin
                    check($sformatf("rnd%0d gap busy", r), busy, 1'b0);
                    @(negedge rclk);
                end
                for (int j = 0; j < n; j++) begin
                    b = 8'($urandom);
                    push(b);
                    exp_q.push_back(b);
                end
            end
            b = exp_q.pop_front();
            if ($urandom_range(0, 3) == 0) pk = int'($urandom_range(0, FLEN - 1));
            else pk = -1;
            nb = 8'($urandom);
            run_frame(model_bits(b), pk, nb, $sformatf("rnd%0d %02h", r, b), waited);
            if (pk >= 0) exp_q.push_back(nb);
            check($sformatf("rnd%0d pop_latency", r), waited, 1);
            r++;
        end

        repeat (4) @(negedge rclk);
        check("final ren_pulses", ren_cnt, wr_cnt);
        check("final ren_on_empty", ren_on_empty, 0);
        check("final empty", fifo_empty, 1'b1);
        check("final busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
